alarm_ctrl_fsm_mc: RTL and testbench

- Parametrised key-entry/alarm control FSM for the alarm clock. Sits between the keypad scanner, the 1 Hz timebase and the time/alarm registers.
- Generalises the single-alarm controller to NUM_ALARMS alarm channels, a configurable entry timeout and a bounded digit count.
- A single shared timeout counter replaces per-state counters.
- A key press in KEY_ENTRY goes to KEY_STORED.

---
 rtl/alarm_ctrl_pkg.sv | 25 ++
 rtl/alarm_ctrl_timeout_cnt.sv | 31 +++
 rtl/alarm_ctrl_fsm_mc.sv | 140 ++++++++++++++
 tb/tb_alarm_ctrl_fsm_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the alarm clock key-entry controller.
package alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4,
    SET_ALARM  = 3'd5,
    SET_TIME   = 3'd6
  } state_e;

  localparam logic [3:0] NO_KEY_DEF    = 4'd10;
  localparam logic [3:0] ABORT_KEY_DEF = 4'd11;

  // Wide enough for TIMEOUT_SEC up to 63.
  localparam int TIMER_W = 6;

  // Bits needed to hold n distinct values, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_ctrl_timeout_cnt.sv
// Saturating one_second counter; time_out flags that the entry window has expired.
module alarm_ctrl_timeout_cnt
  import alarm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic time_out
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_SEC);

  logic [TIMER_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr)                        timer_d = '0;
    else if (tick && timer_q != LIMIT) timer_d = timer_q + TIMER_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign time_out = (timer_q == LIMIT);

endmodule

// File: rtl/alarm_ctrl_fsm_mc.sv
// Multi-channel key-entry / alarm control FSM for the alarm clock.
// Optional abort key enabled by defining ALARM_CTRL_ABORT_EN.
module alarm_ctrl_fsm_mc
  import alarm_ctrl_pkg::*;
#(
  parameter int         NUM_ALARMS  = 2,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         MAX_DIGITS  = 4,
  parameter logic [3:0] NO_KEY      = NO_KEY_DEF,
  parameter logic [3:0] ABORT_KEY   = ABORT_KEY_DEF,
  localparam int        AW          = width_of(NUM_ALARMS),
  localparam int        DW          = width_of(MAX_DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  time_button,
  input  logic                  alarm_button,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [3:0]            key,
  output logic [AW-1:0]         alarm_idx,
  output logic                  show_a,
  output logic                  show_new_time,
  output logic                  shift,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic [DW-1:0]         digit_cnt
);

  localparam logic [DW-1:0] MAXD = DW'(MAX_DIGITS);

  state_e          state_q, state_d;
  logic [AW-1:0]   alarm_idx_q, alarm_idx_d;
  logic [DW-1:0]   digit_cnt_q, digit_cnt_d;
  logic            time_out;
  logic            timer_clr;
  logic            key_hit;

  function automatic logic [AW-1:0] clamp(input logic [AW-1:0] x);
    return (32'(x) < NUM_ALARMS) ? x : '0;
  endfunction

`ifdef ALARM_CTRL_ABORT_EN
  logic abort_hit;
  assign abort_hit = (key == ABORT_KEY);
  // The abort key never opens a session from SHOW_TIME.
  assign key_hit   = (key != NO_KEY) && !abort_hit;
`else
  logic unused_abort_key;
  assign unused_abort_key = ^ABORT_KEY;
  assign key_hit          = (key != NO_KEY);
`endif

  always_comb begin
    state_d     = state_q;
    alarm_idx_d = alarm_idx_q;
    digit_cnt_d = digit_cnt_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_d     = SHOW_ALARM;
          alarm_idx_d = clamp(alarm_sel);
        end else if (key_hit) begin
          state_d = KEY_STORED;
        end
      end
      KEY_STORED: begin
        state_d = KEY_WAITED;
        if (shift) digit_cnt_d = digit_cnt_q + DW'(1);
      end
      KEY_WAITED: begin
        if (key == NO_KEY)  state_d = KEY_ENTRY;
`ifdef ALARM_CTRL_ABORT_EN
        else if (abort_hit) state_d = SHOW_TIME;
`endif
        else if (time_out)  state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button) begin
          state_d     = SET_ALARM;
          alarm_idx_d = clamp(alarm_sel);
        end
        else if (time_button)  state_d = SET_TIME;
`ifdef ALARM_CTRL_ABORT_EN
        else if (abort_hit)    state_d = SHOW_TIME;
`endif
        else if (time_out)     state_d = SHOW_TIME;
        else if (key != NO_KEY) state_d = KEY_STORED;
      end
      SHOW_ALARM: if (!alarm_button) state_d = SHOW_TIME;
      SET_ALARM:  state_d = SHOW_TIME;
      SET_TIME:   state_d = SHOW_TIME;
      default:    state_d = SHOW_TIME;
    endcase
    // Clearing on entry as well keeps digit_cnt at 0 for the whole SHOW_TIME stay.
    if (state_q == SHOW_TIME || state_d == SHOW_TIME) digit_cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SHOW_TIME;
      alarm_idx_q <= '0;
      digit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      alarm_idx_q <= alarm_idx_d;
      digit_cnt_q <= digit_cnt_d;
    end
  end

  // Any state change restarts the window, so each key press gets a fresh timeout.
  assign timer_clr = (state_d != state_q) ||
                     !(state_q == KEY_WAITED || state_q == KEY_ENTRY);

  alarm_ctrl_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr      (timer_clr),
    .tick     (one_second),
    .time_out (time_out)
  );

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++)
      load_new_a[i] = (state_q == SET_ALARM) && (32'(alarm_idx_q) == i);
  end

  assign alarm_idx     = alarm_idx_q;
  assign digit_cnt     = digit_cnt_q;
  assign show_a        = (state_q == SHOW_ALARM);
  assign show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                         (state_q == KEY_ENTRY);
  assign shift         = (state_q == KEY_STORED) && (digit_cnt_q < MAXD);
  assign load_new_c    = (state_q == SET_TIME);
  assign reset_count   = load_new_c;

endmodule

// File: tb/tb_alarm_ctrl_fsm_mc.sv
// Directed self-checking bench for alarm_ctrl_fsm_mc (4-channel main DUT, 5-channel DUT for clamping).
module tb_alarm_ctrl_fsm_mc;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second, time_button, alarm_button;
  logic [1:0] alarm_sel;
  logic [2:0] alarm_sel5;
  logic [3:0] key;

  logic [1:0] alarm_idx;
  logic       show_a, show_new_time, shift, load_new_c, reset_count;
  logic [3:0] load_new_a;
  logic [2:0] digit_cnt;

  logic [2:0] alarm_idx5;
  logic       show_a5, show_new_time5, shift5, load_new_c5, reset_count5;
  logic [4:0] load_new_a5;
  logic [2:0] digit_cnt5;

  int n_checks = 0;
  int n_errors = 0;
  int shift_cnt = 0;
  int load_cnt  = 0;
  int s0, l0;

  always #5 clock = ~clock;

  alarm_ctrl_fsm_mc #(.NUM_ALARMS(4)) u_dut (
    .clock(clock), .reset(reset), .one_second(one_second),
    .time_button(time_button), .alarm_button(alarm_button),
    .alarm_sel(alarm_sel), .key(key), .alarm_idx(alarm_idx),
    .show_a(show_a), .show_new_time(show_new_time), .shift(shift),
    .load_new_a(load_new_a), .load_new_c(load_new_c),
    .reset_count(reset_count), .digit_cnt(digit_cnt)
  );

  alarm_ctrl_fsm_mc #(.NUM_ALARMS(5)) u_dut5 (
    .clock(clock), .reset(reset), .one_second(one_second),
    .time_button(time_button), .alarm_button(alarm_button),
    .alarm_sel(alarm_sel5), .key(key), .alarm_idx(alarm_idx5),
    .show_a(show_a5), .show_new_time(show_new_time5), .shift(shift5),
    .load_new_a(load_new_a5), .load_new_c(load_new_c5),
    .reset_count(reset_count5), .digit_cnt(digit_cnt5)
  );

  always @(negedge clock) begin
    if (shift) shift_cnt <= shift_cnt + 1;
    if (load_new_c || (|load_new_a)) load_cnt <= load_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Key down for one edge, released for the next: lands in KEY_ENTRY.
  task automatic press_key(input logic [3:0] k);
    key = k;
    step();
    key = 4'd10;
    step();
    step();
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      one_second = 1'b1;
      step();
    end
    one_second = 1'b0;
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; time_button = 1'b0; alarm_button = 1'b0;
    alarm_sel = 2'd0; alarm_sel5 = 3'd0; key = 4'd10;
    step(); step();
    chk("rst_outs", {alarm_idx, show_a, show_new_time, shift, load_new_a,
                     load_new_c, reset_count, digit_cnt}, 32'h0);
    reset = 1'b0;
    step();

    // Single key then commit to current time.
    s0 = shift_cnt;
    key = 4'd5; step();
    chk("stored_shift", shift, 1);
    chk("stored_snt", show_new_time, 1);
    key = 4'd10; step();
    chk("waited_cnt", digit_cnt, 1);
    chk("waited_shift", shift, 0);
    step();
    chk("entry_snt", show_new_time, 1);
    time_button = 1'b1; step(); time_button = 1'b0;
    chk("set_time_ld", {load_new_c, reset_count}, 2'b11);
    chk("set_time_snt", show_new_time, 0);
    step();
    chk("t1_idle", {alarm_idx, show_a, show_new_time, shift, load_new_a,
                    load_new_c, reset_count, digit_cnt}, 32'h0);
    chk("t1_shifts", shift_cnt - s0, 1);

    // Four digits to alarm channel 2.
    s0 = shift_cnt;
    alarm_sel = 2'd2; alarm_sel5 = 3'd2;
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd0);
    chk("t2_cnt", digit_cnt, 4);
    chk("t2_shifts", shift_cnt - s0, 4);
    alarm_button = 1'b1; step(); alarm_button = 1'b0;
    chk("t2_load_a", load_new_a, 4'b0100);
    chk("t2_idx", alarm_idx, 2);
    chk("t2_ldc", load_new_c, 0);
    step();
    chk("t2_load_a_off", load_new_a, 0);
    chk("t2_cnt_clr", digit_cnt, 0);

    // Show alarm: clamp on the 5-channel DUT, freeze while held.
    alarm_sel = 2'd3; alarm_sel5 = 3'd5; alarm_button = 1'b1; step();
    chk("sa_show", show_a, 1);
    chk("sa_idx", alarm_idx, 3);
    chk("sa_clamp_idx", alarm_idx5, 0);
    chk("sa_clamp_show", show_a5, 1);
    alarm_sel = 2'd1; key = 4'd7; step(); key = 4'd10;
    chk("sa_frozen", alarm_idx, 3);
    chk("sa_hold", {show_a, show_new_time}, 2'b10);
    alarm_button = 1'b0; step();
    chk("sa_release", show_a, 0);
    chk("sa_idx_kept", alarm_idx, 3);
    step();

    // Timeout with no input.
    l0 = load_cnt;
    press_key(4'd5);
    secs(9);
    chk("to_9", show_new_time, 1);
    secs(1);
    chk("to_10", show_new_time, 1);
    step();
    chk("to_exit", show_new_time, 0);
    chk("to_cnt", digit_cnt, 0);
    // Second key restarts the window.
    press_key(4'd5);
    secs(6);
    press_key(4'd6);
    secs(9);
    chk("to_restart_9", show_new_time, 1);
    secs(1);
    step();
    chk("to_restart_exit", show_new_time, 0);
    chk("to_no_load", load_cnt - l0, 0);

    // Six keys, four accepted.
    s0 = shift_cnt;
    for (int i = 0; i < 6; i++) press_key(4'(i + 1));
    chk("sat_shifts", shift_cnt - s0, 4);
    chk("sat_cnt", digit_cnt, 4);
    time_button = 1'b1; step(); time_button = 1'b0;
    chk("sat_set_time", load_new_c, 1);
    step();

    // Both buttons: alarm wins.
    press_key(4'd1);
    alarm_sel = 2'd1; alarm_button = 1'b1; time_button = 1'b1; step();
    alarm_button = 1'b0; time_button = 1'b0;
    chk("both_load_a", load_new_a, 4'b0010);
    chk("both_ldc", load_new_c, 0);
    step();

    // Button beats an expired timeout in the same cycle.
    press_key(4'd2);
    secs(10);
    time_button = 1'b1; step(); time_button = 1'b0;
    chk("btn_vs_to", load_new_c, 1);
    step();

    // Asynchronous reset mid-entry.
    l0 = load_cnt;
    key = 4'd5; step(); step();
    chk("kw_snt", show_new_time, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {alarm_idx, show_a, show_new_time, shift, load_new_a,
                      load_new_c, reset_count, digit_cnt}, 32'h0);
    key = 4'd10;
    step();
    reset = 1'b0;
    step(); step();
    chk("rst_no_load", load_cnt - l0, 0);
    chk("rst_idle", show_new_time, 0);

`ifdef ALARM_CTRL_ABORT_EN
    s0 = shift_cnt;
    key = 4'd11; step(); key = 4'd10;
    chk("abort_ignored_idle", show_new_time, 0);
    press_key(4'd1); press_key(4'd2);
    key = 4'd11; step(); key = 4'd10;
    chk("abort_exit", show_new_time, 0);
    chk("abort_cnt", digit_cnt, 0);
    chk("abort_shifts", shift_cnt - s0, 2);
    step();
`else
    s0 = shift_cnt;
    key = 4'd11; step(); key = 4'd10;
    chk("key11_stored", show_new_time, 1);
    step(); step();
    chk("key11_cnt", digit_cnt, 1);
    chk("key11_shifts", shift_cnt - s0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
